// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: single-clock FIFO pointer/flag controller for a dual-port memory
// Optional build macro FIFO_CTRL_ERR_FLAGS_EN enables sticky overflow/underflow flags.
// Ports: i_clk/i_rst (async active-high) clock and reset; i_wr_en/i_rd_en push/pop requests;
//        o_b_wr_ptr/o_b_rd_ptr binary pointers with wrap MSB; o_mem_wr_en/o_mem_rd_en gated
//        memory enables; o_full/o_empty/o_almost_full/o_almost_empty registered flags;
//        o_count occupancy; o_rd_valid read data valid; o_overflow/o_underflow sticky errors.
module fifo_sync_ctrl #(
   parameter int DEPTH     = 512,
   parameter int AF_THRESH = DEPTH - 4,
   parameter int AE_THRESH = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_wr_en,
   input  logic                     i_rd_en,
   output logic [$clog2(DEPTH):0]   o_b_wr_ptr,
   output logic [$clog2(DEPTH):0]   o_b_rd_ptr,
   output logic                     o_mem_wr_en,
   output logic                     o_mem_rd_en,
   output logic                     o_full,
   output logic                     o_empty,
   output logic                     o_almost_full,
   output logic                     o_almost_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_rd_valid,
   output logic                     o_overflow,
   output logic                     o_underflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   logic [AW:0] r_wr_ptr, r_rd_ptr, r_count, w_cnt_nxt;
   logic        r_full, r_empty, r_afull, r_aempty, r_rd_valid;
   logic        w_wr_acc, w_rd_acc;
   assign w_wr_acc  = i_wr_en & ~r_full;
   assign w_rd_acc  = i_rd_en & ~r_empty;
   assign w_cnt_nxt = (w_wr_acc & ~w_rd_acc) ? r_count + PW'(1) :
                      (w_rd_acc & ~w_wr_acc) ? r_count - PW'(1) : r_count;
   // Flags are computed from the next count so they track the pointers with no lag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_full     <= 1'b0;
         r_empty    <= 1'b1;
         r_afull    <= 1'b0;
         r_aempty   <= 1'b1;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
         r_count    <= w_cnt_nxt;
         r_full     <= w_cnt_nxt == PW'(DEPTH);
         r_empty    <= w_cnt_nxt == '0;
         r_afull    <= w_cnt_nxt >= PW'(AF_THRESH);
         r_aempty   <= w_cnt_nxt <= PW'(AE_THRESH);
         r_rd_valid <= w_rd_acc;
      end
   end
   // Count-derived flags must agree with the pointer relationship.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         assert (r_full == ((r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0])));
         assert (r_empty == (r_wr_ptr == r_rd_ptr));
      end
   end
`ifdef FIFO_CTRL_ERR_FLAGS_EN
   logic r_ovf, r_unf;
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (i_wr_en & r_full)  r_ovf <= 1'b1;
         if (i_rd_en & r_empty) r_unf <= 1'b1;
      end
   end
   assign o_overflow  = r_ovf;
   assign o_underflow = r_unf;
`else
   assign o_overflow  = 1'b0;
   assign o_underflow = 1'b0;
`endif
   assign o_b_wr_ptr     = r_wr_ptr;
   assign o_b_rd_ptr     = r_rd_ptr;
   assign o_mem_wr_en    = w_wr_acc;
   assign o_mem_rd_en    = w_rd_acc;
   assign o_full         = r_full;
   assign o_empty        = r_empty;
   assign o_almost_full  = r_afull;
   assign o_almost_empty = r_aempty;
   assign o_count        = r_count;
   assign o_rd_valid     = r_rd_valid;
endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// tb_fifo_sync_ctrl: queue-model checked bench for fifo_sync_ctrl (DEPTH=8, AF=6, AE=2)
module tb_fifo_sync_ctrl;
   logic       clk = 1'b0, rst, wr, rd;
   logic [3:0] wp, rp, cnt;
   logic       mwe, mre, full, empty, afull, aempty, rv, ovf, unf;
   int         checks = 0, failures = 0;
   int         q[$];
   int         n_push, n_pop, tag;
   bit         m_rv, m_ovf, m_unf;
   always #5 clk = ~clk;
   fifo_sync_ctrl #(.DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_wr_en(wr), .i_rd_en(rd),
      .o_b_wr_ptr(wp), .o_b_rd_ptr(rp), .o_mem_wr_en(mwe), .o_mem_rd_en(mre),
      .o_full(full), .o_empty(empty), .o_almost_full(afull), .o_almost_empty(aempty),
      .o_count(cnt), .o_rd_valid(rv), .o_overflow(ovf), .o_underflow(unf));
   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask
   task automatic check_model();
      int c = q.size();
      chk("count", cnt, c);
      chk("wr_ptr", wp, n_push % 16);
      chk("rd_ptr", rp, n_pop % 16);
      chk("full", full, c == 8);
      chk("empty", empty, c == 0);
      chk("almost_full", afull, c >= 6);
      chk("almost_empty", aempty, c <= 2);
      chk("rd_valid", rv, m_rv);
      chk("mem_wr_en", mwe, wr && c < 8);
      chk("mem_rd_en", mre, rd && c > 0);
      chk("overflow", ovf, m_ovf);
      chk("underflow", unf, m_unf);
   endtask
   task automatic drive(bit w, bit r);
      @(negedge clk);
      wr = w;
      rd = r;
      #1 check_model();
   endtask
   task automatic edge_upd();
      bit wa, ra;
      @(posedge clk);
      wa = wr && q.size() < 8;
      ra = rd && q.size() > 0;
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      if (wr && q.size() == 8) m_ovf = 1;
      if (rd && q.size() == 0) m_unf = 1;
`endif
      if (ra) void'(q.pop_front());
      if (wa) q.push_back(tag++);
      n_push += int'(wa);
      n_pop  += int'(ra);
      m_rv = ra;
      #2;
   endtask
   task automatic cyc(bit w, bit r);
      drive(w, r);
      edge_upd();
   endtask
   task automatic model_clear();
      q.delete();
      n_push = 0; n_pop = 0; m_rv = 0; m_ovf = 0; m_unf = 0;
   endtask
   task automatic do_reset();
      @(negedge clk);
      #2 rst = 1; wr = 0; rd = 0;
      #1;
      chk("rst_count", cnt, 0);
      chk("rst_wr_ptr", wp, 0);
      chk("rst_rd_ptr", rp, 0);
      chk("rst_empty", empty, 1);
      chk("rst_full", full, 0);
      chk("rst_aempty", aempty, 1);
      chk("rst_afull", afull, 0);
      chk("rst_rd_valid", rv, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_unf", unf, 0);
      model_clear();
      @(negedge clk);
      rst = 0;
   endtask
   initial begin
      rst = 1; wr = 0; rd = 0; tag = 0;
      model_clear();
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (3) cyc(0, 0);
      chk("idle_wp", wp, 0);
      chk("idle_empty", empty, 1);
      chk("idle_count", cnt, 0);
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 0);
         chk("fill_count", cnt, i);
         chk("fill_aempty", aempty, i <= 2);
         chk("fill_afull", afull, i >= 6);
      end
      chk("fill_full", full, 1);
      chk("fill_wp", wp, 4'b1000);
      drive(1, 1);
      chk("full_push_rejected", mwe, 0);
      chk("full_pop_accepted", mre, 1);
      edge_upd();
      chk("full_pp_count", cnt, 7);
      chk("full_pp_full", full, 0);
      drive(0, 0);
      chk("full_pp_rd_valid", rv, 1);
      edge_upd();
      do_reset();
      repeat (8) cyc(1, 0);
      repeat (8) cyc(0, 1);
      repeat (3) cyc(1, 0);
      chk("wrap_wp", wp, 4'b1011);
      chk("wrap_rp", rp, 4'b1000);
      chk("wrap_count", cnt, 3);
      repeat (3) cyc(0, 1);
      chk("drained_empty", empty, 1);
      cyc(1, 1);
      chk("empty_pp_count", cnt, 1);
      chk("empty_pp_rd_valid", rv, 0);
      for (int i = 0; i < 10; i++) begin
         cyc(1, 1);
         chk("stream_count", cnt, 1);
         chk("stream_rd_valid", rv, 1);
      end
      do_reset();
      cyc(0, 1);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("underflow_set", unf, 1);
`else
      chk("underflow_off", unf, 0);
`endif
      repeat (5) cyc(1, 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("underflow_sticky", unf, 1);
`else
      chk("underflow_off2", unf, 0);
`endif
      repeat (4) cyc(1, 0);
`ifdef FIFO_CTRL_ERR_FLAGS_EN
      chk("overflow_set", ovf, 1);
`else
      chk("overflow_off", ovf, 0);
`endif
      do_reset();
      repeat (3) cyc(1, 0);
      cyc(1, 1);
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int pw = (i / 200) % 3 == 0 ? 80 : (i / 200) % 3 == 1 ? 20 : 50;
         if (i % 700 == 699) do_reset();
         cyc($urandom_range(99) < pw, $urandom_range(99) < 100 - pw);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
